gcd_job_sequencer: RTL and testbench

//  Upstream feeder and downstream collector for the GCD core. Buffers operand pairs from a

---
 rtl/gcd_job_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: buffers operand pairs in a FIFO, issues one GCD core job at a time and
// returns the result on a valid/ready sink. Optional RUN timeout: define GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int WIDTH          = 63,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  output logic             gcd_load,
  input  logic             gcd_valid,
  input  logic [WIDTH-1:0] gcd_result
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  state_t               state_r, state_s;
  logic [2*WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r, count_s;
  logic                 in_ready_r;
  logic                 push_s, pop_s;
  logic [2*WIDTH-1:0]   head_s;
  logic [WIDTH-1:0]     head_a_s, head_b_s;
  logic                 out_valid_r, out_err_r, gcd_load_r;
  logic [WIDTH-1:0]     out_result_r, gcd_a_r, gcd_b_r;
  logic                 err_s;
  logic [WIDTH-1:0]     result_s, gcd_a_s, gcd_b_s;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_s   = in_valid && in_ready_r;
  assign pop_s    = (state_r == IDLE) && (count_r != {CNT_W{1'b0}});
  assign head_s   = mem_r[rd_ptr_r];
  assign head_a_s = head_s[2*WIDTH-1:WIDTH];
  assign head_b_s = head_s[WIDTH-1:0];

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [RUN_W-1:0] run_cnt_r;
  logic             timeout_s;

  assign timeout_s = (run_cnt_r == RUN_W'(TIMEOUT_CYCLES - 1));

  // RUN-cycle counter, cleared while the job is being loaded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt_r <= {RUN_W{1'b0}};
    end else if (state_r == LOAD) begin
      run_cnt_r <= {RUN_W{1'b0}};
    end else if (state_r == RUN) begin
      run_cnt_r <= run_cnt_r + RUN_W'(1);
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end
`endif

  // FIFO storage; emptiness is tracked by count_r, so the data needs no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_a, in_b};
    end
  end

  // Occupancy update.
  always_comb begin
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      count_s = count_r - CNT_W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Next state; the popped pair is classified in the pop cycle itself.
  always_comb begin
    state_s  = state_r;
    err_s    = out_err_r;
    result_s = out_result_r;
    gcd_a_s  = gcd_a_r;
    gcd_b_s  = gcd_b_r;
    case (state_r)
      IDLE: begin
        if (!pop_s) begin
          state_s = IDLE;
        end else if (head_a_s == MIN_VAL || head_b_s == MIN_VAL) begin
          state_s  = DONE;
          err_s    = 1'b1;
          result_s = ZERO_VAL;
        end else if (head_a_s == ZERO_VAL || head_b_s == ZERO_VAL) begin
          state_s  = DONE;
          err_s    = 1'b0;
          result_s = abs_mag(head_a_s) + abs_mag(head_b_s);
        end else begin
          state_s = LOAD;
          gcd_a_s = head_a_s;
          gcd_b_s = head_b_s;
        end
      end
      // gcd_valid still reflects the previous job here, so it is not looked at.
      LOAD: state_s = RUN;
      RUN: begin
        if (gcd_valid) begin
          state_s  = DONE;
          err_s    = 1'b0;
          result_s = gcd_result;
        end
`ifdef GCD_SEQ_TIMEOUT_EN
        else if (timeout_s) begin
          state_s  = DONE;
          err_s    = 1'b1;
          result_s = ZERO_VAL;
        end
`endif
        else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, FIFO pointers and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_err_r    <= 1'b0;
      out_result_r <= ZERO_VAL;
      gcd_load_r   <= 1'b0;
      gcd_a_r      <= ZERO_VAL;
      gcd_b_r      <= ZERO_VAL;
    end else begin
      state_r      <= state_s;
      wr_ptr_r     <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r     <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      count_r      <= count_s;
      in_ready_r   <= (count_s != CNT_W'(FIFO_DEPTH));
      out_valid_r  <= (state_s == DONE);
      out_err_r    <= err_s;
      out_result_r <= result_s;
      gcd_load_r   <= (state_s == LOAD);
      gcd_a_r      <= gcd_a_s;
      gcd_b_r      <= gcd_b_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_err    = out_err_r;
  assign out_result = out_result_r;
  assign gcd_load   = gcd_load_r;
  assign gcd_a      = gcd_a_r;
  assign gcd_b      = gcd_b_r;

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a behavioural subtractive GCD core stub;
// expected results come from a Euclid reference model.
module tb_gcd_job_sequencer;
  localparam int W = 63;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  typedef struct { logic err; logic [W-1:0] res; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } ld_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic out_err;
  logic [W-1:0] gcd_a, gcd_b, gcd_result;
  logic gcd_load, gcd_valid;

  logic [W-1:0] core_x = '0;
  logic [W-1:0] core_y = '0;
  logic stall = 1'b0;
  int   ready_mode = 1;
  int   hold_cnt = 0;
  logic prev_load = 1'b0;

  exp_t exp_q[$];
  ld_t  ld_q[$];
  int   checks = 0;
  int   failures = 0;

  gcd_job_sequencer #(.FIFO_DEPTH(4), .WIDTH(W), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_load(gcd_load),
    .gcd_valid(gcd_valid), .gcd_result(gcd_result)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] mag63(input logic [W-1:0] v);
    return v[W-1] ? (~v + 63'd1) : v;
  endfunction

  // Core stub: no reset, subtract until y reaches zero.
  always @(posedge clock) begin
    if (gcd_load) begin
      core_x <= mag63(gcd_a);
      core_y <= mag63(gcd_b);
    end else if (core_y != '0) begin
      if (core_x > core_y) core_x <= core_x - core_y;
      else                 core_y <= core_y - core_x;
    end
  end
  assign gcd_valid  = !stall && (core_y == '0);
  assign gcd_result = core_x;

  function automatic logic [W-1:0] sv(input longint v);
    return v[W-1:0];
  endfunction

  function automatic longint smag(input logic [W-1:0] v);
    longint s;
    s = longint'({v[W-1], v});
    return (s < 0) ? -s : s;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint x, y, t;
    if (a == MIN_V || b == MIN_V) begin
      e.err = 1'b1;
      e.res = '0;
      return e;
    end
    x = smag(a);
    y = smag(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    e.err = 1'b0;
    e.res = x[W-1:0];
    return e;
  endfunction

  function automatic bit needs_core(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a != MIN_V) && (b != MIN_V) && (a != '0) && (b != '0);
  endfunction

  function automatic logic [W-1:0] rand_op();
    int unsigned r;
    longint m;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return MIN_V;
    m = longint'($urandom_range(1, 600));
    if ($urandom_range(0, 1) == 1) m = -m;
    return sv(m);
  endfunction

  task automatic note(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    note("push_accepted", in_ready, 1);
    if (in_ready) begin
      @(posedge clock);
      exp_q.push_back(model(a, b));
      if (needs_core(a, b)) ld_q.push_back('{a, b});
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clock); #1;
      n++;
    end
    note("drain_done", exp_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    ld_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    note("in_ready_after_reset", in_ready, 1);
  endtask

  // out_ready driver: random, always, hold-5-then-accept, or never.
  initial begin
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: out_ready = ($urandom_range(0, 1) == 1);
        1: out_ready = 1'b1;
        2: begin
          if (out_valid && !out_ready) hold_cnt++;
          else hold_cnt = 0;
          out_ready = (hold_cnt >= 5);
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented output and every core load with the queues.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        note("reset_out_valid", out_valid, 0);
        note("reset_in_ready", in_ready, 0);
        prev_load = 1'b0;
      end else begin
        if (gcd_load) begin
          note("load_single_pulse", prev_load, 0);
          note("load_expected", ld_q.size() != 0, 1);
          if (ld_q.size() != 0) begin
            note("gcd_a", gcd_a, ld_q[0].a);
            note("gcd_b", gcd_b, ld_q[0].b);
            void'(ld_q.pop_front());
          end
        end
        prev_load = gcd_load;
        if (out_valid) begin
          note("out_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            note("out_err", out_err, exp_q[0].err);
            note("out_result", out_result, exp_q[0].res);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    note("rst_out_valid", out_valid, 0);
    note("rst_out_err", out_err, 0);
    note("rst_out_result", out_result, 0);
    note("rst_gcd_load", gcd_load, 0);
    note("rst_gcd_a", gcd_a, 0);
    note("rst_gcd_b", gcd_b, 0);
    note("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    note("in_ready_after_reset", in_ready, 1);

    // T1
    ready_mode = 1;
    push(sv(48), sv(18));
    drain();

    // T2: fill while the sink stalls, then release each result after 5 held cycles
    ready_mode = 3;
    push(sv(-48), sv(18));
    push(sv(35), sv(-14));
    push(sv(17), sv(17));
    push(sv(48), sv(30));
    push(sv(9), sv(0));
    note("in_ready_full", in_ready, 0);
    ready_mode = 2;
    drain();

    // T3 and T4
    ready_mode = 0;
    push(sv(0), sv(-7));
    push(sv(9), sv(0));
    push(sv(0), sv(0));
    push(MIN_V, sv(5));
    push(sv(12), sv(8));
    push(sv(7), MIN_V);
    drain();

    // T5: reset two cycles into RUN
    ready_mode = 1;
    push(sv(1000), sv(1));
    push(sv(3), sv(3));
    n = 0;
    while (!gcd_load && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    note("t5_load_seen", gcd_load, 1);
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    push(sv(21), sv(6));
    drain();

    // Randomised jobs
    for (int i = 0; i < 40; i++) begin
      ready_mode = (i < 20) ? 0 : 1;
      push(rand_op(), rand_op());
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    drain();

    // T6: core never finishes
    ready_mode = 1;
    stall = 1'b1;
    push(sv(5), sv(3));
`ifdef GCD_SEQ_TIMEOUT_EN
    exp_q[exp_q.size() - 1] = '{1'b1, '0};
    drain();
    stall = 1'b0;
`else
    void'(exp_q.pop_back());
    repeat (60) @(posedge clock);
    #1;
    note("t6_no_output", out_valid, 0);
    stall = 1'b0;
    do_reset();
`endif
    push(sv(12), sv(18));
    drain();

    note("exp_queue_empty", exp_q.size(), 0);
    note("load_queue_empty", ld_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
